usart_tx_sched: RTL and testbench
=================================

USART_TX_SCHED -- requirements
Module: usart_tx_sched

Interface
REQ-001 SHALL have parameter UBRR_VAL, default 12'h081, the baud divisor written to UBRRnH/UBRRnL.
REQ-002 SHALL have parameter UCSRA_VAL, default 8'h00, the value written to UCSRnA.
REQ-003 SHALL have parameter UCSRC_VAL, default 8'h06, the value written to UCSRnC (8N1 async).
REQ-004 SHALL have ports, one per line:
- cp2  in  1  system clock
- ireset  in  1  synchronous reset, active-low
- ram_Addr  out  12  USART register address
- ramwe  out  1  register write strobe
- ramre  out  1  register read strobe
- dbus_out  out  8  write data to USART
- dbus_in  in  8  read data from USART
- udre  in  1  USART UDREn status (data register empty)
- RxcIRQ  in  1  USART receive-complete
- req0, req1  in  1 each  transmit requests
- data0, data1  in  8 each  transmit bytes
- ack0, ack1  out  1 each  one-cycle grant/consume pulse
- rx_data  out  8  received byte
- rx_valid  out  1  one-cycle received-byte strobe
- init_done  out  1  init sequence complete

Function
REQ-005 FSM states SHALL be INIT_WR, INIT_GAP, IDLE, TX_WR, TX_WAIT, RX_RD, RX_CAP.
REQ-006 After reset, SHALL perform 5 writes, each one cycle with ramwe=1 followed by one gap cycle with ramwe=0: 0x0C5<={4'h0,UBRR_VAL[11:8]}, 0x0C4<=UBRR_VAL[7:0], 0x0C0<=UCSRA_VAL, 0x0C1<=UCSRB value, 0x0C2<=UCSRC_VAL.
REQ-007 init_done SHALL rise on the cycle after the fifth gap cycle (cycle 10 after reset release) and stay high until reset.
REQ-008 In IDLE, when udre=1 and req0 or req1 is high, SHALL enter TX_WR: ram_Addr=0x0C6, ramwe=1, dbus_out=data of the winner, and ack of the winner=1, all in the same cycle.
REQ-009 Arbitration SHALL be 2-way round robin: with both requests high, the requester not granted last wins; after reset req0 has priority.
REQ-010 A single request SHALL be granted regardless of the round-robin pointer; the pointer updates only on grant.
REQ-011 TX_WAIT SHALL last exactly 2 cycles (UDRE update latency) before returning to IDLE; no grant during TX_WAIT.
REQ-012 With udre=0, requests SHALL be held without ack; no data loss, no timeout.
REQ-013 Requests SHALL be ignored until init_done=1.
REQ-014 ramwe and ramre SHALL never be high in the same cycle; strobes last exactly one cycle.

Reset
REQ-015 With ireset=0 at a cp2 rising edge: ram_Addr=0, ramwe=0, ramre=0, dbus_out=0, ack0=ack1=0, rx_data=0, rx_valid=0, init_done=0, RR pointer=req0, state=INIT_WR.
REQ-016 Reset mid-operation (any state) SHALL abort the in-flight transfer, issue no ack, and restart the full init sequence.

Configuration
REQ-017 With USART_SCHED_RX_EN defined: UCSRB value=8'h18 (RXEN|TXEN); in IDLE, RxcIRQ=1 SHALL take priority over TX, entering RX_RD (ram_Addr=0x0C6, ramre=1, one cycle), then RX_CAP (rx_data<=dbus_in, rx_valid=1 one cycle), then IDLE.
REQ-018 Without USART_SCHED_RX_EN: UCSRB value=8'h08 (TXEN only); RxcIRQ ignored; rx_data/rx_valid tied to 0; RX_RD/RX_CAP absent.

Structure
REQ-019 Shared package usart_pkg SHALL hold register address constants (0x0C0, 0x0C1, 0x0C2, 0x0C4, 0x0C5, 0x0C6), the FSM state enumeration and the UCSRB values.
REQ-020 Round-robin arbitration SHALL be a sub-module usart_sched_rr_arb (req[1:0], grant_en -> gnt[1:0], internal pointer).

Verification
REQ-021 Release reset -> exactly 5 ramwe pulses at cycles 0,2,4,6,8 to 0x0C5/0x0C4/0x0C0/0x0C1/0x0C2 with data 0x00/0x81/0x00/0x18 (0x08 without macro)/0x06; init_done=1 at cycle 10.
REQ-022 udre=1, req0 with data0=8'h65 -> same-cycle ack0, ramwe, ram_Addr=0x0C6, dbus_out=0x65; next grant no earlier than 3 cycles later.
REQ-023 req0 and req1 held high continuously, udre=1 -> acks alternate ack0, ack1, ack0, ...; data 0x65/0x55 appear in that order.
REQ-024 udre=0 for 20 cycles with req1 high -> no ack, no ramwe; udre rising -> ack1 in the first IDLE cycle.
REQ-025 (macro on) RxcIRQ and req0 both high in IDLE, USART returning 0x55 -> ramre at 0x0C6 first, rx_valid with rx_data=0x55 next cycle, then ack0.
REQ-026 ireset=0 during TX_WAIT and during INIT_GAP -> all outputs at reset values next cycle; init sequence replays fully after release.

Source files
------------

// File: rtl/usart_pkg.sv
// rtl/usart_pkg.sv - USART register map, scheduler FSM states and UCSRB values
// RX_RD/RX_CAP exist only when USART_SCHED_RX_EN is defined.
package usart_pkg;

  localparam logic [11:0] ADDR_UCSRA = 12'h0C0;
  localparam logic [11:0] ADDR_UCSRB = 12'h0C1;
  localparam logic [11:0] ADDR_UCSRC = 12'h0C2;
  localparam logic [11:0] ADDR_UBRRL = 12'h0C4;
  localparam logic [11:0] ADDR_UBRRH = 12'h0C5;
  localparam logic [11:0] ADDR_UDR   = 12'h0C6;

  localparam logic [7:0] UCSRB_TX_ONLY = 8'h08;
  localparam logic [7:0] UCSRB_RX_TX   = 8'h18;

  localparam int INIT_WRITES = 5;

  typedef enum logic [2:0] {
    INIT_WR,
    INIT_GAP,
    IDLE,
    TX_WR,
    TX_WAIT
`ifdef USART_SCHED_RX_EN
    ,
    RX_RD,
    RX_CAP
`endif
  } sched_state_t;

endpackage

// File: rtl/usart_sched_rr_arb.sv
// rtl/usart_sched_rr_arb.sv - two-way round-robin arbiter for the USART transmit requesters
module usart_sched_rr_arb (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);

  // Set when requester 1 won last, which hands priority to requester 0.
  logic last1;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last1 ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last1 <= 1'b1;
    end else if (grant_en && (gnt != 2'b00)) begin
      last1 <= gnt[1];
    end
  end

endmodule

// File: rtl/usart_tx_sched.sv
// rtl/usart_tx_sched.sv - USART init sequencer and two-requester transmit scheduler
// Optional receive path enabled by defining USART_SCHED_RX_EN.
module usart_tx_sched
  import usart_pkg::*;
#(
  parameter logic [11:0] UBRR_VAL  = 12'h081,
  parameter logic [7:0]  UCSRA_VAL = 8'h00,
  parameter logic [7:0]  UCSRC_VAL = 8'h06
) (
  input  logic        cp2,
  input  logic        ireset,
  output logic [11:0] ram_Addr,
  output logic        ramwe,
  output logic        ramre,
  output logic [7:0]  dbus_out,
  input  logic [7:0]  dbus_in,
  input  logic        udre,
  input  logic        RxcIRQ,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  data0,
  input  logic [7:0]  data1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        init_done
);

`ifdef USART_SCHED_RX_EN
  localparam logic [7:0] UCSRB_VAL = UCSRB_RX_TX;
`else
  localparam logic [7:0] UCSRB_VAL = UCSRB_TX_ONLY;
`endif

  sched_state_t state;
  logic [2:0]   init_idx;
  logic         wait_cnt;
  logic [11:0]  init_addr;
  logic [7:0]   init_data;
  logic [1:0]   gnt;
  logic         rx_pending;
  logic         grant_en;

  always_comb begin
    init_addr = ADDR_UBRRH;
    init_data = {4'h0, UBRR_VAL[11:8]};
    case (init_idx)
      3'd1:    begin init_addr = ADDR_UBRRL; init_data = UBRR_VAL[7:0]; end
      3'd2:    begin init_addr = ADDR_UCSRA; init_data = UCSRA_VAL;     end
      3'd3:    begin init_addr = ADDR_UCSRB; init_data = UCSRB_VAL;     end
      3'd4:    begin init_addr = ADDR_UCSRC; init_data = UCSRC_VAL;     end
      default: ;
    endcase
  end

`ifdef USART_SCHED_RX_EN
  assign rx_pending = RxcIRQ;
`else
  logic unused_rx;
  assign rx_pending = 1'b0;
  assign unused_rx  = ^{RxcIRQ, dbus_in};
  assign rx_data    = 8'h00;
  assign rx_valid   = 1'b0;
`endif

  // A pending receive blocks the grant so the RR pointer does not advance.
  assign grant_en = (state == IDLE) && init_done && udre && !rx_pending;

  usart_sched_rr_arb u_arb (
    .clk      (cp2),
    .resetn   (ireset),
    .req      ({req1, req0}),
    .grant_en (grant_en),
    .gnt      (gnt)
  );

  always_ff @(posedge cp2) begin
    if (!ireset) begin
      state     <= INIT_WR;
      init_idx  <= 3'd0;
      wait_cnt  <= 1'b0;
      ram_Addr  <= 12'h000;
      ramwe     <= 1'b0;
      ramre     <= 1'b0;
      dbus_out  <= 8'h00;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      init_done <= 1'b0;
`ifdef USART_SCHED_RX_EN
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
`endif
    end else begin
      ramwe <= 1'b0;
      ramre <= 1'b0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
`ifdef USART_SCHED_RX_EN
      rx_valid <= 1'b0;
`endif
      case (state)
        INIT_WR: begin
          ram_Addr <= init_addr;
          dbus_out <= init_data;
          ramwe    <= 1'b1;
          state    <= INIT_GAP;
        end
        INIT_GAP: begin
          if (init_idx == 3'(INIT_WRITES - 1)) begin
            state <= IDLE;
          end else begin
            init_idx <= init_idx + 3'd1;
            state    <= INIT_WR;
          end
        end
        IDLE: begin
          if (!init_done) begin
            init_done <= 1'b1;
`ifdef USART_SCHED_RX_EN
          end else if (RxcIRQ) begin
            ram_Addr <= ADDR_UDR;
            ramre    <= 1'b1;
            state    <= RX_RD;
`endif
          end else if (grant_en && (gnt != 2'b00)) begin
            ram_Addr <= ADDR_UDR;
            dbus_out <= gnt[1] ? data1 : data0;
            ramwe    <= 1'b1;
            ack0     <= gnt[0];
            ack1     <= gnt[1];
            state    <= TX_WR;
          end
        end
        TX_WR: begin
          wait_cnt <= 1'b0;
          state    <= TX_WAIT;
        end
        // Two cycles for the USART to drop UDRE after a data write.
        TX_WAIT: begin
          wait_cnt <= 1'b1;
          if (wait_cnt) begin
            state <= IDLE;
          end
        end
`ifdef USART_SCHED_RX_EN
        RX_RD: begin
          rx_data  <= dbus_in;
          rx_valid <= 1'b1;
          state    <= RX_CAP;
        end
        RX_CAP: begin
          state <= IDLE;
        end
`endif
        default: begin
          state <= INIT_WR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usart_tx_sched.sv
// tb/tb_usart_tx_sched.sv - scoreboard bench for usart_tx_sched with randomized requests
module tb_usart_tx_sched;

  localparam int K_WR  = 0;
  localparam int K_RD  = 1;
  localparam int K_RXV = 2;

  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [7:0]  data;
    logic        a0;
    logic        a1;
    int          cyc;
    bit          exact;
  } ev_t;

  logic        cp2 = 1'b0;
  logic        ireset = 1'b0;
  logic [11:0] ram_Addr;
  logic        ramwe, ramre;
  logic [7:0]  dbus_out;
  logic [7:0]  dbus_in = 8'h00;
  logic        udre;
  logic        RxcIRQ = 1'b0;
  logic        req0, req1;
  logic [7:0]  data0, data1;
  logic        ack0, ack1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        init_done;

  ev_t        exp_q[$];
  logic [7:0] src0[$];
  logic [7:0] src1[$];
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = -1;
  int         last_rr = 1;
  int         last_ack = -100;
  bit         udre_force = 1'b1;
  logic       udre_val = 1'b1;
  ev_t        mon_e;
  int         mon_k;

  usart_tx_sched dut (
    .cp2       (cp2),
    .ireset    (ireset),
    .ram_Addr  (ram_Addr),
    .ramwe     (ramwe),
    .ramre     (ramre),
    .dbus_out  (dbus_out),
    .dbus_in   (dbus_in),
    .udre      (udre),
    .RxcIRQ    (RxcIRQ),
    .req0      (req0),
    .req1      (req1),
    .data0     (data0),
    .data1     (data1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .init_done (init_done)
  );

  always #5 cp2 = ~cp2;

  always @(posedge cp2) cyc <= ireset ? cyc + 1 : -1;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input logic [11:0] addr, input logic [7:0] data,
                         input logic a0, input logic a1, input int c, input bit exact);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data;
    e.a0 = a0; e.a1 = a1; e.cyc = c; e.exact = exact;
    exp_q.push_back(e);
  endtask

  // Reference: both queues presented at once, round robin while both non-empty.
  task automatic issue(input int min_cyc);
    int i, j, w;
    i = 0; j = 0;
    while (i < qa.size() || j < qb.size()) begin
      if (i < qa.size() && j < qb.size()) w = (last_rr == 1) ? 0 : 1;
      else if (i < qa.size()) w = 0;
      else w = 1;
      push_ev(K_WR, 12'h0C6, (w == 0) ? qa[i] : qb[j], w == 0, w == 1, min_cyc, 1'b0);
      if (w == 0) i++; else j++;
      last_rr = w;
    end
    foreach (qa[k]) src0.push_back(qa[k]);
    foreach (qb[k]) src1.push_back(qb[k]);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((src0.size() != 0 || src1.size() != 0 || exp_q.size() != 0) && n < 400) begin
      @(negedge cp2);
      n++;
    end
    @(negedge cp2);
    check(exp_q.size() == 0 && src0.size() == 0 && src1.size() == 0, name,
          exp_q.size() + src0.size() + src1.size(), 0);
    exp_q.delete(); src0.delete(); src1.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check({ram_Addr, ramwe, ramre, dbus_out, ack0, ack1, rx_data, rx_valid, init_done} == 34'd0,
          name, {ram_Addr, ramwe, ramre, dbus_out, ack0, ack1, rx_data, rx_valid, init_done}, 0);
  endtask

  task automatic push_init();
    logic [7:0] ucsrb;
`ifdef USART_SCHED_RX_EN
    ucsrb = 8'h18;
`else
    ucsrb = 8'h08;
`endif
    push_ev(K_WR, 12'h0C5, 8'h00,  1'b0, 1'b0, 0, 1'b1);
    push_ev(K_WR, 12'h0C4, 8'h81,  1'b0, 1'b0, 2, 1'b1);
    push_ev(K_WR, 12'h0C0, 8'h00,  1'b0, 1'b0, 4, 1'b1);
    push_ev(K_WR, 12'h0C1, ucsrb,  1'b0, 1'b0, 6, 1'b1);
    push_ev(K_WR, 12'h0C2, 8'h06,  1'b0, 1'b0, 8, 1'b1);
  endtask

  task automatic reset_and_init(input bit early_req);
    @(negedge cp2);
    ireset = 1'b0;
    @(negedge cp2);
    check_reset_outputs("reset_state");
    @(negedge cp2);
    exp_q.delete(); src0.delete(); src1.delete();
    last_rr = 1;
    push_init();
    if (early_req) begin
      qa.delete(); qb.delete();
      qb.push_back(8'($urandom));
      issue(11);
    end
    ireset = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge cp2);
      if (cyc == 9) check(init_done == 1'b0, "init_done_early", init_done, 0);
      if (cyc == 10) begin
        check(init_done == 1'b1, "init_done_cycle10", init_done, 1);
        break;
      end
    end
  endtask

  // Requester models: hold a byte until acked, then present the next one.
  always @(negedge cp2) begin
    if (ack0 === 1'b1 && src0.size() != 0) void'(src0.pop_front());
    if (ack1 === 1'b1 && src1.size() != 0) void'(src1.pop_front());
    req0  = (src0.size() != 0);
    data0 = req0 ? src0[0] : 8'h00;
    req1  = (src1.size() != 0);
    data1 = req1 ? src1[0] : 8'h00;
    udre  = udre_force ? udre_val : ($urandom_range(0, 3) != 0);
  end

  // Monitor: every bus strobe, ack or rx_valid must match the scoreboard head.
  always @(negedge cp2) begin
    if (cyc <= 0) last_ack = -100;
    if (ramwe === 1'b1 || ramre === 1'b1 || rx_valid === 1'b1 || ack0 === 1'b1 || ack1 === 1'b1) begin
      check(!(ramwe && ramre), "we_re_overlap", {ramwe, ramre}, 0);
      mon_k = ramwe ? K_WR : ramre ? K_RD : rx_valid ? K_RXV : 3;
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_event", mon_k, -1);
      end else begin
        mon_e = exp_q.pop_front();
        check(mon_k == mon_e.kind, "event_kind", mon_k, mon_e.kind);
        if (mon_k == K_WR)
          check({ram_Addr, dbus_out, ack0, ack1} == {mon_e.addr, mon_e.data, mon_e.a0, mon_e.a1},
                "write_addr_data_ack", {ram_Addr, dbus_out, ack0, ack1},
                {mon_e.addr, mon_e.data, mon_e.a0, mon_e.a1});
        if (mon_k == K_RD)
          check({ram_Addr, ack0, ack1} == {12'h0C6, 2'b00}, "read_addr", {ram_Addr, ack0, ack1},
                {12'h0C6, 2'b00});
        if (mon_k == K_RXV)
          check(rx_data == mon_e.data, "rx_data", rx_data, mon_e.data);
        if (mon_e.exact) check(cyc == mon_e.cyc, "event_cycle", cyc, mon_e.cyc);
        else check(cyc >= mon_e.cyc, "event_min_cycle", cyc, mon_e.cyc);
      end
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        check(cyc - last_ack >= 3, "ack_spacing", cyc - last_ack, 3);
        last_ack = cyc;
      end
    end
  end

  initial begin
    int na, nb;
    bit seen, quiet;
    logic [7:0] b;

    reset_and_init(1'b0);

    // Both requesters held: alternation 0x65/0x55 starting with req0.
    udre_force = 1'b1; udre_val = 1'b1;
    qa.delete(); qb.delete();
    for (int k = 0; k < 3; k++) begin qa.push_back(8'h65); qb.push_back(8'h55); end
    issue(0);
    wait_drain("alternate_drain");

    qa.delete(); qb.delete();
    qa.push_back(8'h65);
    issue(0);
    wait_drain("single_req0_drain");

    // udre low holds a request without ack or write.
    udre_val = 1'b0;
    qa.delete(); qb.delete();
    qb.push_back(8'($urandom));
    issue(0);
    quiet = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge cp2);
      if (ack1 || ramwe) quiet = 1'b0;
    end
    check(quiet, "udre_low_hold", quiet, 1);
    udre_val = 1'b1;
    wait_drain("udre_rise_drain");

    for (int r = 0; r < 6; r++) begin
      na = $urandom_range(0, 4);
      nb = $urandom_range(0, 4);
      if (na + nb == 0) na = 1;
      qa.delete(); qb.delete();
      for (int k = 0; k < na; k++) qa.push_back(8'($urandom));
      for (int k = 0; k < nb; k++) qb.push_back(8'($urandom));
      udre_force = 1'b0;
      issue(0);
      wait_drain("random_round_drain");
    end

    // Receive-complete alongside a transmit request.
    udre_force = 1'b1; udre_val = 1'b1;
    repeat (4) @(negedge cp2);
    b = 8'($urandom);
    dbus_in = b;
`ifdef USART_SCHED_RX_EN
    push_ev(K_RD, 12'h0C6, 8'h00, 1'b0, 1'b0, 0, 1'b0);
    push_ev(K_RXV, 12'h000, b, 1'b0, 1'b0, 0, 1'b0);
`endif
    qa.delete(); qb.delete();
    qa.push_back(8'($urandom));
    issue(0);
    RxcIRQ = 1'b1;
`ifdef USART_SCHED_RX_EN
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge cp2);
      if (ramre) seen = 1'b1;
    end
    check(seen, "rx_read_seen", seen, 1);
`endif
    RxcIRQ = 1'b1;
    wait_drain("rx_and_tx_drain");
    RxcIRQ = 1'b0;

    // Reset during TX_WAIT.
    qa.delete(); qb.delete();
    qa.push_back(8'($urandom));
    issue(0);
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge cp2);
      if (ack0) seen = 1'b1;
    end
    check(seen, "ack_before_reset", seen, 1);
    @(negedge cp2);
    ireset = 1'b0;
    @(negedge cp2);
    check_reset_outputs("reset_in_tx_wait");
    reset_and_init(1'b0);

    // Reset during INIT_GAP, then full replay with a request raised during init.
    @(negedge cp2);
    ireset = 1'b0;
    @(negedge cp2);
    @(negedge cp2);
    exp_q.delete();
    last_rr = 1;
    push_init();
    ireset = 1'b1;
    for (int n = 0; n < 10 && cyc != 3; n++) @(negedge cp2);
    ireset = 1'b0;
    @(negedge cp2);
    check_reset_outputs("reset_in_init_gap");
    reset_and_init(1'b1);
    wait_drain("early_req_drain");

    qa.delete(); qb.delete();
    qa.push_back(8'($urandom)); qb.push_back(8'($urandom)); qb.push_back(8'($urandom));
    udre_force = 1'b0;
    issue(0);
    wait_drain("after_replay_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
